// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module  : door_pkg
// Brief   : Shared state encoding, motor codes and counter-width helper for
//           the automatic door controller and related timed FSMs.
// Revision: 1.0 - initial release
// ============================================================================
package door_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_ALARM   = 3'd4
  } door_state_e;

  localparam logic [1:0] MOTOR_STOP  = 2'b00;
  localparam logic [1:0] MOTOR_OPEN  = 2'b01;
  localparam logic [1:0] MOTOR_CLOSE = 2'b10;

  // Bits needed to hold 0..bound-1, never less than one bit.
  function automatic int cnt_width(input int bound);
    int w;
    w = $clog2(bound);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : door_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Brief   : Clock-enable generator. Emits a one-cycle tick every DIV clocks;
//           the first tick arrives DIV cycles after reset release.
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler
  import door_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = cnt_width(DIV);

  logic [CNT_W-1:0] div_cnt;

  assign tick = (div_cnt == CNT_W'(DIV - 1));

  // Free-running divider counter, wraps to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/door_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : door_ctrl_fsm
// Brief   : Moore controller for a motorised automatic door with limit
//           switches, travel timeout, hold-open timer and bounded obstruction
//           retries. Optional feature macro: DOOR_LOCK_EN (lock request
//           blocks opening from CLOSED).
// Revision: 1.0 - initial release
// ============================================================================
module door_ctrl_fsm
  import door_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int HOLD_TICKS   = 5,
  parameter int TRAVEL_TICKS = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sense,
  input  logic       obs,
  input  logic       lim_open,
  input  logic       lim_closed,
  input  logic       alarm_ack,
  input  logic       lock,
  output logic [1:0] motor,
  output logic       alarm,
  output logic [2:0] state,
  output logic       tick_led
);

  localparam int HOLD_W   = cnt_width(HOLD_TICKS);
  localparam int TRAVEL_W = cnt_width(TRAVEL_TICKS);
  localparam int RETRY_W  = cnt_width(MAX_RETRIES);

  logic tick;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Bit order: {lock, alarm_ack, lim_closed, lim_open, obs, sense}
  logic [5:0] sync_meta;
  logic [5:0] sync_out;

  // Two-flop synchronisers for every asynchronous sensor and request input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= {lock, alarm_ack, lim_closed, lim_open, obs, sense};
      sync_out  <= sync_meta;
    end
  end

  logic sense_s, obs_s, lim_open_s, lim_closed_s, ack_s, lock_s;
  assign {lock_s, ack_s, lim_closed_s, lim_open_s, obs_s, sense_s} = sync_out;

  // Opening request from CLOSED; the lock only ever gates this one path.
  logic open_req;
`ifdef DOOR_LOCK_EN
  assign open_req = sense_s & ~lock_s;
`else
  logic unused_lock;
  assign unused_lock = lock_s;
  assign open_req    = sense_s;
`endif

  door_state_e         cur_state, next_state;
  logic [TRAVEL_W-1:0] travel, next_travel;
  logic [HOLD_W-1:0]   hold, next_hold;
  logic [RETRY_W-1:0]  retry, next_retry;

  // State, counters and tick LED advance only on prescaler ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= ST_CLOSED;
      travel    <= '0;
      hold      <= '0;
      retry     <= '0;
      tick_led  <= 1'b0;
    end else if (tick) begin
      cur_state <= next_state;
      travel    <= next_travel;
      hold      <= next_hold;
      retry     <= next_retry;
      tick_led  <= ~tick_led;
    end
  end

  // Next-state and counter logic, priority order per state.
  always_comb begin
    next_state  = cur_state;
    next_travel = travel;
    next_hold   = hold;
    next_retry  = retry;
    case (cur_state)
      ST_CLOSED: begin
        if (open_req) next_state = ST_OPENING;
      end
      ST_OPENING: begin
        if (lim_open_s && lim_closed_s)               next_state = ST_ALARM;
        else if (lim_open_s)                          next_state = ST_OPEN;
        else if (travel == TRAVEL_W'(TRAVEL_TICKS-1)) next_state = ST_ALARM;
        else                                          next_travel = travel + TRAVEL_W'(1);
      end
      ST_OPEN: begin
        if (sense_s || obs_s)                     next_hold  = '0;
        else if (hold == HOLD_W'(HOLD_TICKS - 1)) next_state = ST_CLOSING;
        else                                      next_hold  = hold + HOLD_W'(1);
      end
      ST_CLOSING: begin
        if (lim_open_s && lim_closed_s) begin
          next_state = ST_ALARM;
        end else if (obs_s) begin
          if (retry == RETRY_W'(MAX_RETRIES - 1)) begin
            next_state = ST_ALARM;
          end else begin
            next_state = ST_OPENING;
            next_retry = retry + RETRY_W'(1);
          end
        end else if (sense_s) begin
          next_state = ST_OPENING;
        end else if (lim_closed_s) begin
          next_state = ST_CLOSED;
          next_retry = '0;
        end else if (travel == TRAVEL_W'(TRAVEL_TICKS - 1)) begin
          next_state = ST_ALARM;
        end else begin
          next_travel = travel + TRAVEL_W'(1);
        end
      end
      ST_ALARM: begin
        if (ack_s && !obs_s) begin
          next_state = ST_OPENING;
          next_retry = '0;
        end
      end
      default: begin
        next_state = ST_CLOSED;
        next_retry = '0;
      end
    endcase
    // Both timers restart whenever the state changes.
    if (next_state != cur_state) begin
      next_travel = '0;
      next_hold   = '0;
    end
  end

  // Moore output decode; illegal codes drive the safe stop/no-alarm value.
  always_comb begin
    motor = MOTOR_STOP;
    alarm = 1'b0;
    case (cur_state)
      ST_OPENING: motor = MOTOR_OPEN;
      ST_CLOSING: motor = MOTOR_CLOSE;
      ST_ALARM:   alarm = 1'b1;
      default:    motor = MOTOR_STOP;
    endcase
  end

  assign state = cur_state;

endmodule : door_ctrl_fsm
`default_nettype wire

// File: tb/tb_door_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_door_ctrl_fsm
// Brief   : Scoreboard bench for door_ctrl_fsm. Each tick-step pushes the
//           expected Moore outputs; a monitor pops on every tick_led toggle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_door_ctrl_fsm;

  localparam int TICK_DIV     = 4;
  localparam int HOLD_TICKS   = 3;
  localparam int TRAVEL_TICKS = 4;
  localparam int MAX_RETRIES  = 2;

  localparam logic [2:0] S_CL = 3'd0, S_OPG = 3'd1, S_OP = 3'd2, S_CLG = 3'd3, S_AL = 3'd4;

  logic clk = 1'b0;
  logic rst_n, sense, obs, lim_open, lim_closed, alarm_ack, lock;
  logic [1:0] motor;
  logic       alarm;
  logic [2:0] state;
  logic       tick_led;

  door_ctrl_fsm #(
    .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS),
    .TRAVEL_TICKS(TRAVEL_TICKS), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sense(sense), .obs(obs),
    .lim_open(lim_open), .lim_closed(lim_closed), .alarm_ack(alarm_ack),
    .lock(lock), .motor(motor), .alarm(alarm), .state(state), .tick_led(tick_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] st;
    logic [1:0] mot;
    logic       alm;
    logic       led;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  logic exp_led = 1'b0;

  function automatic logic [1:0] motor_of(input logic [2:0] st);
    if (st == S_OPG) return 2'b01;
    if (st == S_CLG) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Apply inputs right after a tick, expect st after the next tick.
  task automatic step(input logic s, o, lo, lc, ack, lk, input logic [2:0] st);
    exp_t e;
    sense = s; obs = o; lim_open = lo; lim_closed = lc; alarm_ack = ack; lock = lk;
    exp_led = ~exp_led;
    step_id++;
    e.id = step_id; e.st = st; e.mot = motor_of(st); e.alm = (st == S_AL); e.led = exp_led;
    sb.push_back(e);
    repeat (TICK_DIV) @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every tick_led toggle is one presented output to score.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else if (tick_led !== prev) begin
        prev = tick_led;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: state=%0d with no expectation queued", state);
        end else begin
          e = sb.pop_front();
          if (state !== e.st || motor !== e.mot || alarm !== e.alm || tick_led !== e.led) begin
            errors++;
            $display("FAIL step%0d: got state=%0d motor=%b alarm=%b led=%b expected state=%0d motor=%b alarm=%b led=%b",
                     e.id, state, motor, alarm, tick_led, e.st, e.mot, e.alm, e.led);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset with all inputs asserted.
    rst_n = 1'b0;
    sense = 1; obs = 1; lim_open = 1; lim_closed = 1; alarm_ack = 1; lock = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_motor", int'(motor), 0);
    chk("reset_alarm", int'(alarm), 0);
    chk("reset_led",   int'(tick_led), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sense = 0; obs = 0; lim_open = 0; lim_closed = 0; alarm_ack = 0; lock = 0;

    // First tick: no toggle after 3 clocks, toggle on the 4th.
    exp_led = 1'b1;
    step_id++;
    e.id = step_id; e.st = S_CL; e.mot = 2'b00; e.alm = 1'b0; e.led = 1'b1;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1 chk("no_tick_before_4clk", int'(tick_led), 0);
    @(posedge clk);
    #1 chk("first_tick_at_4clk", int'(tick_led), 1);
    @(negedge clk);

    //     s  o lo lc ak lk  expected
    // Normal cycle
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 0, 0, 0, 0, 0, S_CLG);
    step(0, 0, 0, 1, 0, 0, S_CL);
    step(0, 0, 0, 1, 0, 0, S_CL);
    // Hold extend: sense at second clear tick restarts hold
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(1, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 0, 0, 1, 0, 0, S_CL);
    // Obstruction retries then alarm
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 1, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 1, 0, 0, 0, 0, S_AL);
    step(0, 1, 0, 0, 1, 0, S_AL);
    step(0, 0, 0, 0, 1, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    // Sense during closing reopens without alarm
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 0, 0, 1, 0, 0, S_CL);
    // Opening timeout: alarm on the 4th tick without lim_open
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 0, 0, 0, 0, S_AL);
    step(0, 0, 0, 0, 1, 0, S_OPG);
    // Both limits during closing
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 0, 1, 1, 0, 0, S_AL);
    step(0, 0, 0, 0, 1, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_OP);
    step(0, 0, 1, 0, 0, 0, S_CLG);
    step(0, 0, 0, 1, 0, 0, S_CL);
    // Lock request in CLOSED
`ifdef DOOR_LOCK_EN
    step(1, 0, 0, 0, 0, 1, S_CL);
`else
    step(1, 0, 0, 0, 0, 1, S_OPG);
`endif
    step(1, 0, 0, 0, 0, 0, S_OPG);
    step(0, 0, 1, 0, 0, 0, S_OP);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_door_ctrl_fsm
`default_nettype wire
